timer_scheduler: RTL
====================

// Module: timer_scheduler
// PURPOSE
//  Shares the single countdown timer (timer + time_parameters pair) among NREQ
//  requesters: alarm FSM entry/trigger delay, arm delay, stop-alarm hold, etc.
//  Arbitrates requests and drives the interval select to time_parameters.
//  Issues the start_timer pulse and returns a done pulse to the granted requester.
//  Sits in top between the control FSMs and TIMER_DRIVER/TIME_CONTROL_DRIVER.
// PARAMETERS
//  NREQ  4  number of requesters (>=2)
//  IW    3  interval select width (matches time_parameters interval port)
// PORTS
//  clock          in   1        system clock
//  reset          in   1        synchronous, active-high
//  req            in   NREQ     level request per requester; hold until done
//  req_interval   in   NREQ*IW  interval index per requester, slice i = [i*IW +: IW]
//  expired        in   1        timer expired flag from timer
//  grant          out  NREQ     one-hot current owner, 0 when idle
//  done           out  NREQ     1-cycle pulse to owner when its interval expired
//  busy           out  1        1 in any state except IDLE
//  interval       out  IW       interval select to time_parameters (registered)
//  start_timer    out  1        1-cycle pulse, loads/restarts timer
// BEHAVIOUR
//  Reset (sync, active-high): state=IDLE; grant=0, done=0, busy=0, interval=0,
//    start_timer=0; RR pointer=0. Reset mid-operation aborts silently (no done).
//  All outputs registered. FSM: IDLE -> SELECT -> START -> RUN -> DONE -> IDLE.
//  IDLE: if |req, pick winner w; next cycle grant=onehot(w),
//    interval=req_interval[w], state=SELECT. Else stay.
//  SELECT: 1 cycle, lets time_parameters present value for interval; -> START.
//  START: start_timer=1 for exactly this cycle; expired ignored here; -> RUN.
//  RUN: wait expired=1 -> DONE with done[w]=1 in DONE cycle.
//  DONE: 1 cycle; grant cleared on exit; -> IDLE (re-arbitrate next cycle).
//  Latency: req rises in IDLE at cycle N -> grant N+1, start_timer N+2,
//    expired at cycle M (in RUN) -> done pulse M+1, grant low M+2.
//  Abort: req[w] low in SELECT/START/RUN -> IDLE next cycle, grant=0, no done,
//    no start_timer if aborted before START. Timer left running is harmless;
//    next grant restarts it.
//  Simultaneous req[w] drop and expired in RUN: abort wins, no done.
//  req changes of non-owners while busy are ignored; req_interval[w] is
//    sampled only at grant; later changes have no effect on current run.
//  Requester still asserting req at DONE is re-arbitrated like any other.
//  grant and done are never asserted for more than one requester.
//  busy = (state != IDLE); interval holds last value while IDLE.
// CONFIGURATION
//  TIMER_SCHED_RR_EN defined: round-robin arbitration; search starts at
//    (last_winner+1) mod NREQ; pointer updates on every grant (incl. aborted).
//  Not defined: fixed priority, index 0 highest; no pointer register.
// TESTING
//  1 Single req[1]=1, req_interval[1]=2 -> grant=0010 @+1, interval=2,
//    start_timer pulse @+2, expired in RUN -> done[1] pulse next cycle.
//  2 req=0011 from IDLE, fixed prio -> grant=0001 first; after done[0] and
//    req[0] low -> grant=0010 follows with its own start_timer.
//  3 RR_EN, req=1111 held, 8 serviced runs -> grant order 0,1,2,3,0,1,2,3.
//  4 req[2] dropped during RUN same cycle as expired -> IDLE, done stays 0,
//    grant=0 next cycle.
//  5 expired=1 during SELECT and START -> ignored, no done; RUN still waits
//    for a later expired.
//  6 reset=1 in RUN -> next edge all outputs 0, state IDLE, no done pulse.

Source files
------------

// File: rtl/timer_scheduler_if.sv
// timer_scheduler_if
//   Bundles the requester/timer-side signals of timer_scheduler.
//   slave  : scheduler view (takes req/req_interval/expired, drives the rest)
//   master : requester/timer view (the opposite directions)
// Parameters: NREQ requesters, IW interval select width.
interface timer_scheduler_if #(
    parameter int NREQ = 4,
    parameter int IW   = 3
);
    logic [NREQ-1:0]    req;
    logic [NREQ*IW-1:0] req_interval;
    logic               expired;
    logic [NREQ-1:0]    grant;
    logic [NREQ-1:0]    done;
    logic               busy;
    logic [IW-1:0]      interval;
    logic               start_timer;

    modport slave (
        input  req, req_interval, expired,
        output grant, done, busy, interval, start_timer
    );

    modport master (
        output req, req_interval, expired,
        input  grant, done, busy, interval, start_timer
    );
endinterface

// File: rtl/timer_scheduler.sv
// timer_scheduler
//   Shares one countdown timer among NREQ requesters. A winner is picked from
//   the level requests, its interval index is latched onto `interval`, the
//   timer is (re)started with a one-cycle start_timer pulse, and when the
//   timer expires the owner gets a one-cycle done pulse.
//   Sequence: IDLE -> SELECT -> START -> RUN -> DONE -> IDLE.
//   Dropping the owner's req in SELECT/START/RUN aborts back to IDLE silently.
// Ports:
//   clock, reset   system clock, synchronous active-high reset
//   bus (slave)    req, req_interval, expired in; grant, done, busy,
//                  interval, start_timer out (all registered)
// Configuration:
//   TIMER_SCHED_RR_EN  defined: round-robin arbitration
//                      undefined: fixed priority, index 0 highest
module timer_scheduler #(
    parameter int NREQ = 4,
    parameter int IW   = 3
) (
    input  logic             clock,
    input  logic             reset,
    timer_scheduler_if.slave bus
);
    localparam int IDXW = $clog2(NREQ);

    typedef enum logic [2:0] {
        S_IDLE, S_SELECT, S_START, S_RUN, S_DONE
    } state_t;

    state_t            state, state_nx;
    logic [IDXW-1:0]   owner, owner_nx, win;
    logic              any_req, owner_req;
    logic [NREQ-1:0]   grant_q, grant_nx, done_q, done_nx;
    logic [IW-1:0]     interval_q, interval_nx;
    logic              busy_q, busy_nx, start_q, start_nx;

    assign any_req   = |bus.req;
    assign owner_req = bus.req[owner];

    // Arbiter. Loops run high-to-low so the lowest-ranked candidate is the
    // last assignment and therefore the winner.
`ifdef TIMER_SCHED_RR_EN
    // rr_ptr holds the first index to search, i.e. last winner + 1.
    logic [IDXW-1:0] rr_ptr;
    int              j;

    always_comb begin
        win = '0;
        j   = 0;
        for (int k = NREQ-1; k >= 0; k--) begin
            j = int'(rr_ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (bus.req[j]) win = IDXW'(j);
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            rr_ptr <= '0;
        else if (state == S_IDLE && any_req)
            rr_ptr <= (int'(win) == NREQ-1) ? '0 : win + 1'b1;
    end
`else
    always_comb begin
        win = '0;
        for (int i = NREQ-1; i >= 0; i--)
            if (bus.req[i]) win = IDXW'(i);
    end
`endif

    // State and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            owner      <= '0;
            grant_q    <= '0;
            done_q     <= '0;
            busy_q     <= 1'b0;
            interval_q <= '0;
            start_q    <= 1'b0;
        end else begin
            state      <= state_nx;
            owner      <= owner_nx;
            grant_q    <= grant_nx;
            done_q     <= done_nx;
            busy_q     <= busy_nx;
            interval_q <= interval_nx;
            start_q    <= start_nx;
        end
    end

    // Next state. In RUN an owner drop outranks a coincident expired.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (any_req) state_nx = S_SELECT;
            S_SELECT: state_nx = owner_req ? S_START : S_IDLE;
            S_START:  state_nx = owner_req ? S_RUN : S_IDLE;
            S_RUN:    if (!owner_req)       state_nx = S_IDLE;
                      else if (bus.expired) state_nx = S_DONE;
            S_DONE:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Next values of the registered outputs, decoded from the next state so
    // each output lines up with the state it belongs to.
    always_comb begin
        owner_nx    = owner;
        grant_nx    = grant_q;
        interval_nx = interval_q;
        if (state == S_IDLE && any_req) begin
            owner_nx    = win;
            grant_nx    = NREQ'(1) << win;
            interval_nx = bus.req_interval[int'(win)*IW +: IW];
        end
        if (state_nx == S_IDLE) grant_nx = '0;
        // grant_q is the one-hot owner while in RUN
        done_nx  = (state_nx == S_DONE) ? grant_q : '0;
        start_nx = (state_nx == S_START);
        busy_nx  = (state_nx != S_IDLE);
    end

    assign bus.grant       = grant_q;
    assign bus.done        = done_q;
    assign bus.busy        = busy_q;
    assign bus.interval    = interval_q;
    assign bus.start_timer = start_q;
endmodule
